klp32_dmem_responder: RTL and testbench

Data-memory responder for the KLP32 core's load/store port. It accepts one load or store request at a time over a valid/ready handshake and inserts a configurable number of wait states. It performs RV32I byte/half/word lane selection, sign/zero extension and alignment/range checking. It then returns a one-cycle response pulse carrying read data or an error flag.

---
 rtl/klp32_dmem_responder.sv | 169 ++++++++++++++++
 tb/tb_klp32_dmem_responder.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/klp32_dmem_responder.sv
// Data-memory responder for the KLP32 load/store port: one request at a time,
// WAIT_STATES wait cycles, RV32I lane select/extension and alignment/range checks.
module klp32_dmem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_valid,
  output logic        o_ready,
  input  logic        i_memRW,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  input  logic [2:0]  i_funct3,
  output logic        o_resp_valid,
  output logic [31:0] o_rdata,
  output logic        o_err
);

  localparam int         IDX_W     = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [3:0] WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;
  localparam bit         NO_WAIT   = (WAIT_STATES == 0);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} stateT;

  stateT             state;
  stateT             nextState;
  logic [3:0]        waitCnt;
  logic              accept;
  logic              enterResp;

  logic              latRW;
  logic [31:0]       latAddr;
  logic [31:0]       latWdata;
  logic [2:0]        latFunct3;

  logic              reqRW;
  logic [31:0]       reqAddr;
  logic [31:0]       reqWdata;
  logic [2:0]        reqFunct3;
  logic              reqErr;
  logic [IDX_W-1:0]  wordIdx;
  logic [3:0]        byteEn;
  logic [31:0]       laneData;

  logic [31:0]       rdWord;
  logic [7:0]        byteVal;
  logic [15:0]       halfVal;
  logic [31:0]       loadVal;

  logic [31:0]       rdataReg;
  logic              errReg;

  logic [31:0]       mem [DEPTH_WORDS];

  assign accept = i_valid & o_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      waitCnt <= 4'd0;
    end else begin
      state <= nextState;
      if (accept) begin
        waitCnt <= WAIT_LOAD;
      end else if (state == WAIT && waitCnt != 4'd0) begin
        waitCnt <= waitCnt - 4'd1;
      end
    end
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (accept) nextState = NO_WAIT ? RESP : WAIT;
      WAIT:    if (waitCnt == 4'd0) nextState = RESP;
      RESP:    nextState = accept ? (NO_WAIT ? RESP : WAIT) : IDLE;
      default: nextState = IDLE;
    endcase
  end

  always_comb begin
    o_ready      = (state != WAIT);
    o_resp_valid = (state == RESP);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      latRW     <= 1'b0;
      latAddr   <= '0;
      latWdata  <= '0;
      latFunct3 <= '0;
    end else if (accept) begin
      latRW     <= i_memRW;
      latAddr   <= i_addr;
      latWdata  <= i_wdata;
      latFunct3 <= i_funct3;
    end
  end

  // With no wait states the request completes on its acceptance edge, so it is
  // taken straight from the inputs instead of the capture registers.
  assign reqRW     = NO_WAIT ? i_memRW  : latRW;
  assign reqAddr   = NO_WAIT ? i_addr   : latAddr;
  assign reqWdata  = NO_WAIT ? i_wdata  : latWdata;
  assign reqFunct3 = NO_WAIT ? i_funct3 : latFunct3;
  assign enterResp = NO_WAIT ? accept : (state == WAIT && waitCnt == 4'd0);
  assign wordIdx   = reqAddr[IDX_W+1:2];

  always_comb begin
    reqErr   = 1'b0;
    byteEn   = 4'b0000;
    laneData = reqWdata;
    case (reqFunct3)
      3'b000, 3'b100: begin
        byteEn   = 4'b0001 << reqAddr[1:0];
        laneData = {4{reqWdata[7:0]}};
      end
      3'b001, 3'b101: begin
        byteEn   = reqAddr[1] ? 4'b1100 : 4'b0011;
        laneData = {2{reqWdata[15:0]}};
        reqErr   = reqAddr[0];
      end
      3'b010: begin
        byteEn = 4'b1111;
        reqErr = (reqAddr[1:0] != 2'b00);
      end
      default: reqErr = 1'b1;
    endcase
    if (reqRW && reqFunct3[2]) reqErr = 1'b1;
    if (reqAddr[31:2] >= 30'(DEPTH_WORDS)) reqErr = 1'b1;
  end

  always_comb begin
    rdWord  = mem[wordIdx];
    byteVal = rdWord[{reqAddr[1:0], 3'b000} +: 8];
    halfVal = reqAddr[1] ? rdWord[31:16] : rdWord[15:0];
    case (reqFunct3)
      3'b000:  loadVal = {{24{byteVal[7]}}, byteVal};
      3'b001:  loadVal = {{16{halfVal[15]}}, halfVal};
      3'b100:  loadVal = {24'd0, byteVal};
      3'b101:  loadVal = {16'd0, halfVal};
      default: loadVal = rdWord;
    endcase
  end

  // Array has no reset; a reset during WAIT simply never reaches the commit edge.
  always_ff @(posedge clk) begin
    if (!reset && enterResp && reqRW && !reqErr) begin
      for (int i = 0; i < 4; i++) begin
        if (byteEn[i]) mem[wordIdx][8*i +: 8] <= laneData[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rdataReg <= '0;
      errReg   <= 1'b0;
    end else if (enterResp) begin
      errReg   <= reqErr;
      rdataReg <= (reqErr || reqRW) ? 32'd0 : loadVal;
    end
  end

  assign o_rdata = rdataReg;
  assign o_err   = errReg;

endmodule

// File: tb/tb_klp32_dmem_responder.sv
// Bench for klp32_dmem_responder: directed vectors, reset during WAIT, held-valid
// throughput at 0/1/3 wait states and random traffic against a byte-level model.
module tb_klp32_dmem_responder;

  localparam int DEPTH = 256;
  localparam int WS0   = 1;
  localparam int WS1   = 0;
  localparam int WS2   = 3;

  logic              clk;
  logic              reset;
  logic [2:0]        valid;
  logic [2:0]        memRW;
  logic [2:0][31:0]  addr;
  logic [2:0][31:0]  wdata;
  logic [2:0][2:0]   funct3;
  wire  [2:0]        ready;
  wire  [2:0]        respValid;
  wire  [2:0]        err;
  wire  [2:0][31:0]  rdata;

  int nCompared;
  int nMismatched;
  logic [7:0] refMem [int];

  typedef struct {
    logic        rw;
    logic [31:0] a;
    logic [31:0] wd;
    logic [2:0]  f3;
    logic [31:0] expRd;
    logic        expErr;
  } vecT;

  klp32_dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(WS0)) dut0 (
    .clk(clk), .reset(reset), .i_valid(valid[0]), .o_ready(ready[0]),
    .i_memRW(memRW[0]), .i_addr(addr[0]), .i_wdata(wdata[0]), .i_funct3(funct3[0]),
    .o_resp_valid(respValid[0]), .o_rdata(rdata[0]), .o_err(err[0]));

  klp32_dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(WS1)) dut1 (
    .clk(clk), .reset(reset), .i_valid(valid[1]), .o_ready(ready[1]),
    .i_memRW(memRW[1]), .i_addr(addr[1]), .i_wdata(wdata[1]), .i_funct3(funct3[1]),
    .o_resp_valid(respValid[1]), .o_rdata(rdata[1]), .o_err(err[1]));

  klp32_dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(WS2)) dut2 (
    .clk(clk), .reset(reset), .i_valid(valid[2]), .o_ready(ready[2]),
    .i_memRW(memRW[2]), .i_addr(addr[2]), .i_wdata(wdata[2]), .i_funct3(funct3[2]),
    .o_resp_valid(respValid[2]), .o_rdata(rdata[2]), .o_err(err[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    nCompared++;
    if (actual !== expected) begin
      nMismatched++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  // Presents one request on instance k, holds it until accepted, then waits for the response.
  task automatic applyStimulus(input int k, input logic rw, input logic [31:0] a, input logic [31:0] wd,
                               input logic [2:0] f3, output logic [31:0] rd, output logic e, output int lat);
    int waitCyc;
    memRW[k]  = rw;
    addr[k]   = a;
    wdata[k]  = wd;
    funct3[k] = f3;
    valid[k]  = 1'b1;
    waitCyc   = 0;
    @(negedge clk);
    while (!ready[k] && waitCyc < 40) begin
      @(negedge clk);
      waitCyc++;
    end
    if (!ready[k]) checkOutput("acceptTimeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    valid[k] = 1'b0;
    lat = 0;
    while (!respValid[k] && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    if (!respValid[k]) checkOutput("respTimeout", 32'd0, 32'd1);
    rd = rdata[k];
    e  = err[k];
  endtask

  // Byte-addressed reference: sizes, alignment, range and extension from first principles.
  function automatic void modelAccess(input logic rw, input logic [31:0] a, input logic [31:0] wd,
                                      input logic [2:0] f3, output logic [31:0] rd, output logic e,
                                      output logic known);
    int size;
    logic [31:0] v;
    size  = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    e     = (f3 == 3'd3) || (f3 >= 3'd6) || (rw && f3[2]) || ((a % size) != 0) || ((a >> 2) >= DEPTH);
    v     = 32'd0;
    known = 1'b1;
    rd    = 32'd0;
    if (!e && rw) begin
      for (int i = 0; i < size; i++) refMem[int'(a) + i] = 8'(wd >> (8 * i));
    end else if (!e) begin
      for (int i = 0; i < size; i++) begin
        if (refMem.exists(int'(a) + i)) v = v | (32'(refMem[int'(a) + i]) << (8 * i));
        else known = 1'b0;
      end
      if (!f3[2] && size == 1 && v[7])  v = v | 32'hFFFFFF00;
      if (!f3[2] && size == 2 && v[15]) v = v | 32'hFFFF0000;
      rd = v;
    end
  endfunction

  function automatic vecT mk(input logic rw, input logic [31:0] a, input logic [31:0] wd,
                             input logic [2:0] f3, input logic [31:0] expRd, input logic expErr);
    vecT v;
    v.rw = rw; v.a = a; v.wd = wd; v.f3 = f3; v.expRd = expRd; v.expErr = expErr;
    return v;
  endfunction

  // Holds i_valid high with alternating SW/LW and checks ready/response timing every cycle.
  task automatic throughput(input int k, input int ws);
    logic [31:0] expQ [$];
    logic [31:0] lastVal;
    logic [31:0] expVal;
    int  lastAcc;
    int  nAcc;
    bit  anyAcc;
    bit  accNow;
    bit  isStore;
    bit  expReady;
    bit  expResp;
    lastVal   = $urandom;
    isStore   = 1'b1;
    memRW[k]  = 1'b1;
    addr[k]   = 32'h40;
    wdata[k]  = lastVal;
    funct3[k] = 3'b010;
    valid[k]  = 1'b1;
    anyAcc    = 1'b0;
    lastAcc   = 0;
    nAcc      = 0;
    for (int c = 0; c < 48; c++) begin
      @(negedge clk);
      expReady = !anyAcc || ((c - lastAcc) > ws);
      expResp  = anyAcc && ((c - lastAcc) == ws + 1);
      checkOutput($sformatf("tput%0d.ready.c%0d", ws, c), 32'(ready[k]), 32'(expReady));
      checkOutput($sformatf("tput%0d.respValid.c%0d", ws, c), 32'(respValid[k]), 32'(expResp));
      if (respValid[k]) begin
        if (expQ.size() == 0) begin
          checkOutput($sformatf("tput%0d.spuriousResp.c%0d", ws, c), 32'd1, 32'd0);
        end else begin
          expVal = expQ.pop_front();
          checkOutput($sformatf("tput%0d.rdata.c%0d", ws, c), rdata[k], expVal);
          checkOutput($sformatf("tput%0d.err.c%0d", ws, c), 32'(err[k]), 32'd0);
        end
      end
      accNow = valid[k] && ready[k];
      if (accNow) begin
        anyAcc  = 1'b1;
        lastAcc = c;
        nAcc++;
        expQ.push_back(isStore ? 32'd0 : lastVal);
      end
      @(posedge clk);
      #1;
      if (accNow) begin
        isStore = !isStore;
        if (isStore) begin
          lastVal  = $urandom;
          wdata[k] = lastVal;
        end
        memRW[k] = isStore;
      end
      if (c == 39) valid[k] = 1'b0;
    end
    checkOutput($sformatf("tput%0d.pendingResp", ws), 32'(expQ.size()), 32'd0);
    checkOutput($sformatf("tput%0d.accepts", ws), 32'(nAcc), 32'(39 / (ws + 1) + 1));
  endtask

  initial begin
    vecT         vecs [19];
    logic [31:0] rd;
    logic [31:0] expRd;
    logic        e;
    logic        expErr;
    logic        known;
    logic        rw;
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] wd;
    int          lat;
    int          seen;

    nCompared   = 0;
    nMismatched = 0;
    reset  = 1'b1;
    valid  = '0;
    memRW  = '0;
    addr   = '0;
    wdata  = '0;
    funct3 = '0;

    vecs[0]  = mk(1'b1, 32'h08, 32'h00000002, 3'b010, 32'h00000000, 1'b0);
    vecs[1]  = mk(1'b0, 32'h08, 32'h0,        3'b010, 32'h00000002, 1'b0);
    vecs[2]  = mk(1'b1, 32'h10, 32'h80FF7F01, 3'b010, 32'h00000000, 1'b0);
    vecs[3]  = mk(1'b0, 32'h13, 32'h0,        3'b000, 32'hFFFFFF80, 1'b0);
    vecs[4]  = mk(1'b0, 32'h13, 32'h0,        3'b100, 32'h00000080, 1'b0);
    vecs[5]  = mk(1'b0, 32'h12, 32'h0,        3'b001, 32'hFFFF80FF, 1'b0);
    vecs[6]  = mk(1'b0, 32'h10, 32'h0,        3'b101, 32'h00007F01, 1'b0);
    vecs[7]  = mk(1'b1, 32'h11, 32'h123456AB, 3'b000, 32'h00000000, 1'b0);
    vecs[8]  = mk(1'b1, 32'h12, 32'hCAFE0002, 3'b001, 32'h00000000, 1'b0);
    vecs[9]  = mk(1'b0, 32'h10, 32'h0,        3'b010, 32'h0002AB01, 1'b0);
    vecs[10] = mk(1'b0, 32'h06, 32'h0,        3'b010, 32'h00000000, 1'b1);
    vecs[11] = mk(1'b1, 32'h11, 32'hFFFFFFFF, 3'b001, 32'h00000000, 1'b1);
    vecs[12] = mk(1'b0, 32'h10, 32'h0,        3'b010, 32'h0002AB01, 1'b0);
    vecs[13] = mk(1'b0, 32'h400, 32'h0,       3'b010, 32'h00000000, 1'b1);
    vecs[14] = mk(1'b0, 32'h00, 32'h0,        3'b011, 32'h00000000, 1'b1);
    vecs[15] = mk(1'b1, 32'h10, 32'hFFFFFFFF, 3'b100, 32'h00000000, 1'b1);
    vecs[16] = mk(1'b0, 32'h10, 32'h0,        3'b010, 32'h0002AB01, 1'b0);
    vecs[17] = mk(1'b0, 32'h13, 32'h0,        3'b101, 32'h00000000, 1'b1);
    vecs[18] = mk(1'b1, 32'h20, 32'h00000000, 3'b010, 32'h00000000, 1'b0);

    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      checkOutput($sformatf("reset.ready%0d", k), 32'(ready[k]), 32'd1);
      checkOutput($sformatf("reset.respValid%0d", k), 32'(respValid[k]), 32'd0);
      checkOutput($sformatf("reset.rdata%0d", k), rdata[k], 32'd0);
      checkOutput($sformatf("reset.err%0d", k), 32'(err[k]), 32'd0);
    end
    reset = 1'b0;

    for (int i = 0; i < 19; i++) begin
      applyStimulus(0, vecs[i].rw, vecs[i].a, vecs[i].wd, vecs[i].f3, rd, e, lat);
      checkOutput($sformatf("vec%0d.rdata", i), rd, vecs[i].expRd);
      checkOutput($sformatf("vec%0d.err", i), 32'(e), 32'(vecs[i].expErr));
      checkOutput($sformatf("vec%0d.latency", i), 32'(lat), 32'(WS0));
    end

    // Response fields hold after the pulse ends.
    applyStimulus(0, 1'b0, 32'h08, 32'h0, 3'b010, rd, e, lat);
    checkOutput("hold.first", rd, 32'h00000002);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("hold.rdata", rdata[0], 32'h00000002);
    checkOutput("hold.respValid", 32'(respValid[0]), 32'd0);
    checkOutput("hold.ready", 32'(ready[0]), 32'd1);

    // Reset during WAIT drops a pending store.
    memRW[0]  = 1'b1;
    addr[0]   = 32'h20;
    wdata[0]  = 32'hDEADBEEF;
    funct3[0] = 3'b010;
    valid[0]  = 1'b1;
    @(negedge clk);
    checkOutput("rstWait.readyBefore", 32'(ready[0]), 32'd1);
    @(posedge clk);
    #1;
    valid[0] = 1'b0;
    checkOutput("rstWait.readyInWait", 32'(ready[0]), 32'd0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    checkOutput("rstWait.ready", 32'(ready[0]), 32'd1);
    checkOutput("rstWait.rdata", rdata[0], 32'd0);
    checkOutput("rstWait.err", 32'(err[0]), 32'd0);
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (respValid[0]) seen++;
    end
    checkOutput("rstWait.noResp", 32'(seen), 32'd0);
    applyStimulus(0, 1'b0, 32'h20, 32'h0, 3'b010, rd, e, lat);
    checkOutput("rstWait.loadBack", rd, 32'h00000000);
    checkOutput("rstWait.loadErr", 32'(e), 32'd0);

    throughput(1, WS1);
    throughput(0, WS0);
    throughput(2, WS2);

    // Random traffic over a pre-initialised window plus out-of-range addresses.
    for (int w = 0; w < 16; w++) begin
      wd = $urandom;
      a  = 32'h80 + 32'(4 * w);
      modelAccess(1'b1, a, wd, 3'b010, expRd, expErr, known);
      applyStimulus(0, 1'b1, a, wd, 3'b010, rd, e, lat);
      checkOutput($sformatf("init%0d.err", w), 32'(e), 32'(expErr));
    end
    for (int n = 0; n < 80; n++) begin
      rw = 1'($urandom_range(0, 1));
      f3 = 3'($urandom_range(0, 7));
      wd = $urandom;
      if ($urandom_range(0, 7) == 0) a = 32'h400 + 32'($urandom_range(0, 255));
      else a = 32'h80 + 32'($urandom_range(0, 63));
      modelAccess(rw, a, wd, f3, expRd, expErr, known);
      applyStimulus(0, rw, a, wd, f3, rd, e, lat);
      checkOutput($sformatf("rand%0d.err a=%h f3=%0d rw=%0d", n, a, f3, rw), 32'(e), 32'(expErr));
      if (known || expErr || rw)
        checkOutput($sformatf("rand%0d.rdata a=%h f3=%0d rw=%0d", n, a, f3, rw), rd, expRd);
      checkOutput($sformatf("rand%0d.latency", n), 32'(lat), 32'(WS0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
